// File: rtl/video_pattern_gen.sv
// Video test-pattern source: emits frames of H_ACTIVE x V_ACTIVE pixels over a
// ready/valid link. Four patterns are available: incrementing counter, colour
// bars, animated checkerboard and solid colour. Each beat carries start-of-frame
// and end-of-line markers, and a counter tracks completed frames.
module video_pattern_gen #(
    parameter int CW         = 8,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int BAR_COUNT  = 8,
    parameter int CHECK_LOG2 = 5,
    parameter int FRAME_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [3*CW-1:0]      solid_rgb,
    input  logic                 pix_ready,
    output logic                 pix_valid,
    output logic [3*CW-1:0]      pix_data,
    output logic                 sof,
    output logic                 eol,
    output logic [FRAME_W-1:0]   frame_cnt
);

    localparam int PW    = 3 * CW;
    localparam int BAR_W = H_ACTIVE / BAR_COUNT;

    // x must be wide enough for the bar colour index bits and the checker bit.
    localparam int XW_A  = $clog2(H_ACTIVE) + 1;
    localparam int XW_B  = (XW_A > CHECK_LOG2 + 1) ? XW_A : CHECK_LOG2 + 1;
    localparam int XW    = (XW_B > 3) ? XW_B : 3;
    localparam int YW_A  = $clog2(V_ACTIVE) + 1;
    localparam int YW    = (YW_A > CHECK_LOG2 + 1) ? YW_A : CHECK_LOG2 + 1;

    localparam logic [XW-1:0] X_LAST       = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST       = YW'(V_ACTIVE - 1);
    localparam logic [XW-1:0] BAR_LAST_CNT = XW'(BAR_W - 1);
    localparam logic [XW-1:0] BAR_LAST_IDX = XW'(BAR_COUNT - 1);

    localparam logic [1:0] MODE_INCR    = 2'd0;
    localparam logic [1:0] MODE_BARS    = 2'd1;
    localparam logic [1:0] MODE_CHECKER = 2'd2;
    localparam logic [1:0] MODE_SOLID   = 2'd3;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    // Colour of one pixel, given the pattern and the coordinates of that pixel.
    function automatic logic [PW-1:0] pattern(
        input logic [1:0]    m,
        input logic          cx,
        input logic          cy,
        input logic [2:0]    j,
        input logic [PW-1:0] cnt,
        input logic          odd,
        input logic [PW-1:0] solid
    );
        logic [PW-1:0] res;
        res = '0;
        case (m)
            MODE_INCR:    res = cnt;
            MODE_BARS:    res = {{CW{~j[1]}}, {CW{~j[2]}}, {CW{~j[0]}}};
            MODE_CHECKER: res = (cx ^ cy ^ odd) ? {PW{1'b0}} : {PW{1'b1}};
            MODE_SOLID:   res = solid;
            default:      res = '0;
        endcase
        return res;
    endfunction

    state_t              state, state_next;
    logic [XW-1:0]       x, x_next;
    logic [YW-1:0]       y, y_next;
    logic [XW-1:0]       bar_idx, bar_idx_next;
    logic [XW-1:0]       bar_cnt, bar_cnt_next;
    logic [PW-1:0]       incr_cnt, incr_cnt_next;
    logic [1:0]          mode_l, mode_next;
    logic [PW-1:0]       solid_l, solid_next;
    logic                pix_valid_next;
    logic [PW-1:0]       pix_data_next;
    logic                sof_next, eol_next;
    logic [FRAME_W-1:0]  frame_cnt_next;
    logic                line_end, frame_end, accept, start, load;

    // Next-state logic: walks the raster on each accept and loads the next pixel.
    always_comb begin
        state_next     = state;
        x_next         = x;
        y_next         = y;
        bar_idx_next   = bar_idx;
        bar_cnt_next   = bar_cnt;
        incr_cnt_next  = incr_cnt;
        mode_next      = mode_l;
        solid_next     = solid_l;
        pix_valid_next = pix_valid;
        pix_data_next  = pix_data;
        sof_next       = sof;
        eol_next       = eol;
        frame_cnt_next = frame_cnt;
        start          = 1'b0;
        load           = 1'b0;
        line_end       = (x == X_LAST);
        frame_end      = line_end && (y == Y_LAST);
        accept         = pix_valid && pix_ready;

        case (state)
            IDLE: begin
                if (enable) begin
                    start = 1'b1;
                end else begin
                    pix_valid_next = 1'b0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (frame_end) begin
                        frame_cnt_next = frame_cnt + 1'b1;
                        if (enable) begin
                            start = 1'b1;
                        end else begin
                            state_next     = IDLE;
                            pix_valid_next = 1'b0;
                            sof_next       = 1'b0;
                            eol_next       = 1'b0;
                        end
                    end else begin
                        load          = 1'b1;
                        incr_cnt_next = incr_cnt + 1'b1;
                        if (line_end) begin
                            x_next       = '0;
                            y_next       = y + 1'b1;
                            bar_idx_next = '0;
                            bar_cnt_next = '0;
                        end else begin
                            x_next = x + 1'b1;
                            if ((bar_cnt == BAR_LAST_CNT) && (bar_idx != BAR_LAST_IDX)) begin
                                bar_idx_next = bar_idx + 1'b1;
                                bar_cnt_next = '0;
                            end else begin
                                bar_cnt_next = bar_cnt + 1'b1;
                            end
                        end
                    end
                end else begin
                    // stalled or nothing presented: hold every output
                    state_next = RUN;
                end
            end
            default: begin
                state_next     = IDLE;
                pix_valid_next = 1'b0;
            end
        endcase

        // Frame start: capture the configuration and rewind the raster to (0,0).
        if (start) begin
            state_next    = RUN;
            mode_next     = mode;
            solid_next    = solid_rgb;
            x_next        = '0;
            y_next        = '0;
            bar_idx_next  = '0;
            bar_cnt_next  = '0;
            incr_cnt_next = '0;
            load          = 1'b1;
        end else begin
            load = load;
        end

        if (load) begin
            pix_valid_next = 1'b1;
            sof_next       = (x_next == '0) && (y_next == '0);
            eol_next       = (x_next == X_LAST);
            pix_data_next  = pattern(mode_next, x_next[CHECK_LOG2], y_next[CHECK_LOG2],
                                     bar_idx_next[2:0], incr_cnt_next, frame_cnt_next[0],
                                     solid_next);
        end else begin
            pix_data_next = pix_data_next;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            bar_idx   <= '0;
            bar_cnt   <= '0;
            incr_cnt  <= '0;
            mode_l    <= 2'd0;
            solid_l   <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_next;
            x         <= x_next;
            y         <= y_next;
            bar_idx   <= bar_idx_next;
            bar_cnt   <= bar_cnt_next;
            incr_cnt  <= incr_cnt_next;
            mode_l    <= mode_next;
            solid_l   <= solid_next;
            pix_valid <= pix_valid_next;
            pix_data  <= pix_data_next;
            sof       <= sof_next;
            eol       <= eol_next;
            frame_cnt <= frame_cnt_next;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Testbench for video_pattern_gen with a 16x4 frame. Runs seven consecutive frames
// (INCR, INCR with random backpressure, BARS, CHECKER twice, INCR with a
// mid-frame config change, SOLID with enable dropped mid-frame) and checks them
// against hand-computed vectors.
module tb_video_pattern_gen;

    localparam int CW = 8;
    localparam int H  = 16;
    localparam int V  = 4;
    localparam int NB = H * V;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [1:0]  mode;
    logic [23:0] solid_rgb;
    logic        pix_ready;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        sof;
    logic        eol;
    logic [15:0] frame_cnt;

    video_pattern_gen #(
        .CW(CW), .H_ACTIVE(H), .V_ACTIVE(V), .BAR_COUNT(8), .CHECK_LOG2(1), .FRAME_W(16)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .solid_rgb(solid_rgb),
        .pix_ready(pix_ready), .pix_valid(pix_valid), .pix_data(pix_data),
        .sof(sof), .eol(eol), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    logic [23:0] cap_data [0:6][0:NB-1];
    logic        cap_sof  [0:6][0:NB-1];
    logic        cap_eol  [0:6][0:NB-1];

    typedef struct {
        int          frame;
        int          beat;
        logic [23:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input int f, input int b, input logic [23:0] e);
        vec_t v;
        v.frame = f;
        v.beat  = b;
        v.exp   = e;
        vecs.push_back(v);
    endfunction

    // Capture one frame of accepted beats into slot f. At beat chg_beat the
    // inputs mode/solid_rgb/enable are changed (chg_beat < 0: no change).
    task automatic collect_frame(input int f, input bit rnd, input int chg_beat,
                                 input logic [1:0] chg_mode, input logic [23:0] chg_solid,
                                 input logic chg_en);
        int          n;
        int          cyc;
        logic        stalled;
        logic [23:0] hold_d;
        logic        hold_sof;
        logic        hold_eol;
        n = 0;
        cyc = 0;
        stalled = 1'b0;
        hold_d = '0;
        hold_sof = 1'b0;
        hold_eol = 1'b0;
        forever begin
            if (cyc > 2000) begin
                check("frame_timeout", 32'(n), 32'(NB));
                return;
            end
            if (stalled) begin
                check("stall_hold_data", 32'(pix_data), 32'(hold_d));
                check("stall_hold_sof", 32'(sof), 32'(hold_sof));
                check("stall_hold_eol", 32'(eol), 32'(hold_eol));
            end
            if (n > 0) check("valid_mid_frame", 32'(pix_valid), 32'd1);
            pix_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (pix_valid && pix_ready) begin
                cap_data[f][n] = pix_data;
                cap_sof[f][n]  = sof;
                cap_eol[f][n]  = eol;
                if (n == chg_beat) begin
                    mode      = chg_mode;
                    solid_rgb = chg_solid;
                    enable    = chg_en;
                end
                n++;
            end
            stalled  = pix_valid && !pix_ready;
            hold_d   = pix_data;
            hold_sof = sof;
            hold_eol = eol;
            if (n == NB) break;
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] bar_colors [0:7];
        bar_colors[0] = 24'hFFFFFF; bar_colors[1] = 24'hFFFF00;
        bar_colors[2] = 24'h00FFFF; bar_colors[3] = 24'h00FF00;
        bar_colors[4] = 24'hFF00FF; bar_colors[5] = 24'hFF0000;
        bar_colors[6] = 24'h0000FF; bar_colors[7] = 24'h000000;

        // Frame slots: 0 INCR, 1 INCR random ready, 2 BARS, 3 CHECKER (frame_cnt=3),
        // 4 CHECKER (frame_cnt=4), 5 INCR with switch at beat 5, 6 SOLID.
        add_vec(0, 0, 24'h000000);  add_vec(0, 15, 24'h00000F);
        add_vec(0, 16, 24'h000010); add_vec(0, 47, 24'h00002F);
        add_vec(0, 63, 24'h00003F);
        add_vec(1, 0, 24'h000000);  add_vec(1, 31, 24'h00001F);
        add_vec(1, 63, 24'h00003F);
        for (int x = 0; x < 16; x++) begin
            add_vec(2, x, bar_colors[x / 2]);
            add_vec(2, 48 + x, bar_colors[x / 2]);
        end
        add_vec(3, 0, 24'h000000);  add_vec(3, 2, 24'hFFFFFF);
        add_vec(3, 32, 24'hFFFFFF); add_vec(3, 34, 24'h000000);
        add_vec(4, 0, 24'hFFFFFF);  add_vec(4, 1, 24'hFFFFFF);
        add_vec(4, 2, 24'h000000);  add_vec(4, 3, 24'h000000);
        add_vec(4, 4, 24'hFFFFFF);  add_vec(4, 16, 24'hFFFFFF);
        add_vec(4, 32, 24'h000000); add_vec(4, 34, 24'hFFFFFF);
        add_vec(4, 48, 24'h000000);
        add_vec(5, 5, 24'h000005);  add_vec(5, 6, 24'h000006);
        add_vec(5, 63, 24'h00003F);
        add_vec(6, 0, 24'h123456);  add_vec(6, 63, 24'h123456);

        // Test 1: reset during RUN, then restart
        rst = 1'b1; enable = 1'b0; mode = 2'd0; solid_rgb = 24'h0; pix_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; enable = 1'b1; pix_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("running_before_reset", 32'(pix_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("reset_valid", 32'(pix_valid), 32'd0);
        check("reset_data", 32'(pix_data), 32'd0);
        check("reset_sof", 32'(sof), 32'd0);
        check("reset_eol", 32'(eol), 32'd0);
        check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("restart_valid", 32'(pix_valid), 32'd1);
        check("restart_data", 32'(pix_data), 32'h000000);
        check("restart_sof", 32'(sof), 32'd1);
        check("restart_frame_cnt", 32'(frame_cnt), 32'd0);

        // Test 2: INCR, always ready
        collect_frame(0, 1'b0, -1, 2'd0, 24'h0, 1'b1);
        check("f0_end_frame_cnt", 32'(frame_cnt), 32'd1);
        check("f0_next_valid", 32'(pix_valid), 32'd1);
        check("f0_next_data", 32'(pix_data), 32'h000000);
        check("f0_next_sof", 32'(sof), 32'd1);

        // Test 3: INCR with random backpressure; BARS requested mid-frame
        collect_frame(1, 1'b1, 0, 2'd1, 24'h0, 1'b1);
        check("f1_end_frame_cnt", 32'(frame_cnt), 32'd2);
        check("f1_next_sof", 32'(sof), 32'd1);

        // Test 4: BARS; CHECKER requested for the next frame
        collect_frame(2, 1'b0, 0, 2'd2, 24'h0, 1'b1);
        check("f2_end_frame_cnt", 32'(frame_cnt), 32'd3);

        // Test 5: CHECKER on an odd then an even frame_cnt
        collect_frame(3, 1'b0, -1, 2'd2, 24'h0, 1'b1);
        check("f3_end_frame_cnt", 32'(frame_cnt), 32'd4);
        collect_frame(4, 1'b0, 0, 2'd0, 24'h0, 1'b1);
        check("f4_end_frame_cnt", 32'(frame_cnt), 32'd5);

        // Test 6: switch to SOLID mid-frame, then drop enable mid-frame
        collect_frame(5, 1'b1, 5, 2'd3, 24'h123456, 1'b1);
        check("f5_end_frame_cnt", 32'(frame_cnt), 32'd6);
        check("f5_next_sof", 32'(sof), 32'd1);
        check("f5_next_data", 32'(pix_data), 32'h123456);
        collect_frame(6, 1'b0, 10, 2'd3, 24'h123456, 1'b0);
        check("stop_valid", 32'(pix_valid), 32'd0);
        check("stop_frame_cnt", 32'(frame_cnt), 32'd7);
        repeat (3) @(negedge clk);
        check("idle_valid", 32'(pix_valid), 32'd0);
        check("idle_frame_cnt", 32'(frame_cnt), 32'd7);

        // Markers on every beat of every frame
        for (int f = 0; f < 7; f++) begin
            for (int b = 0; b < NB; b++) begin
                check($sformatf("sof_f%0d_b%0d", f, b), 32'(cap_sof[f][b]), 32'(b == 0));
                check($sformatf("eol_f%0d_b%0d", f, b), 32'(cap_eol[f][b]), 32'((b % H) == H - 1));
            end
        end

        // Full counter sequences and solid frame
        for (int b = 0; b < NB; b++) begin
            check($sformatf("incr_f0_b%0d", b), 32'(cap_data[0][b]), 32'(b));
            check($sformatf("incr_f1_b%0d", b), 32'(cap_data[1][b]), 32'(b));
            check($sformatf("incr_f5_b%0d", b), 32'(cap_data[5][b]), 32'(b));
            check($sformatf("solid_f6_b%0d", b), 32'(cap_data[6][b]), 32'h123456);
        end

        // Hand-computed vector table
        for (int i = 0; i < vecs.size(); i++) begin
            check($sformatf("vec%0d_f%0d_b%0d", i, vecs[i].frame, vecs[i].beat),
                  32'(cap_data[vecs[i].frame][vecs[i].beat]), 32'(vecs[i].exp));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
